ram_bist_loader: RTL and testbench

Parametrised board-level RAM loader and verifier, successor to the fixed-table RAM write harness. Drives the single-master bus of the `ram` controller. Provides four modes:
- probe a single address;
- bulk-load a generated pattern;
- load then verify;
- verify only.

Reports the read word, an error count, the first failing address and pass/done flags for the LED and 7-segment drivers.

---
 rtl/ram_bist_pkg.sv | 21 ++
 rtl/ram_bist_pattern.sv | 16 +
 rtl/ram_bist_loader.sv | 207 ++++++++++++++++++++
 tb/tb_ram_bist_loader.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_bist_pkg.sv
// Shared definitions for the RAM BIST loader: run-mode encodings, FSM states and
// the error-counter width.
package ram_bist_pkg;

   localparam int unsigned ERR_W = 16;

   typedef enum logic [1:0] {
      MODE_PROBE   = 2'b00,
      MODE_LOAD    = 2'b01,
      MODE_LOADVER = 2'b10,
      MODE_VERIFY  = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_GAP  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/ram_bist_pattern.sv
// Index-to-pattern map shared by the write path and the read comparator:
// pattern(i) = SEED + i, truncated to DATA_W.
module ram_bist_pattern #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned IDX_W  = 8,
   parameter logic [31:0] SEED   = 32'hA5A50000
) (
   input  logic [IDX_W-1:0]  idx,
   output logic [DATA_W-1:0] pattern_c
);

   localparam logic [DATA_W-1:0] SEED_W = DATA_W'(SEED);

   assign pattern_c = SEED_W + DATA_W'(idx);

endmodule

// File: rtl/ram_bist_loader.sv
// RAM loader/verifier driving the single-master ram bus: probe, load, load+verify, verify.
// Optional ack watchdog is built when RAM_BIST_TIMEOUT_EN is defined.
module ram_bist_loader
   import ram_bist_pkg::*;
#(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned ADDR_W      = 20,
   parameter int unsigned LOAD_DEPTH  = 256,
   parameter int unsigned BASE_ADDR   = 0,
   parameter logic [31:0] SEED        = 32'hA5A50000,
   parameter int unsigned TIMEOUT_CYC = 1023
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic [1:0]        mode_i,
   input  logic [ADDR_W-1:0] probe_addr_i,
   output logic [31:0]       bus_addr_o,
   output logic [DATA_W-1:0] bus_data_o,
   input  logic [DATA_W-1:0] bus_data_i,
   output logic              bus_ce_o,
   output logic              bus_we_o,
   input  logic              bus_ack_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              pass_o,
   output logic              timeout_o,
   output logic [ERR_W-1:0]  err_count_o,
   output logic [ADDR_W-1:0] first_err_addr_o,
   output logic [DATA_W-1:0] rd_data_o
);

   localparam int unsigned       IDX_W     = (LOAD_DEPTH > 1) ? $clog2(LOAD_DEPTH) : 1;
   localparam longint unsigned   ADDR_SPAN = 64'd1 << ADDR_W;
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(LOAD_DEPTH - 1);
   localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BASE_ADDR);

   // Reject configurations whose pass would run off the end of the RAM.
   if (LOAD_DEPTH < 1 || TIMEOUT_CYC < 1 || ADDR_W > 32 ||
       (64'(BASE_ADDR) + 64'(LOAD_DEPTH)) > ADDR_SPAN) begin : g_cfg_err
      $error("ram_bist_loader: invalid LOAD_DEPTH/BASE_ADDR/ADDR_W/TIMEOUT_CYC");
   end

   state_t            state_q;
   mode_t             mode_q;
   mode_t             start_mode_c;
   logic [IDX_W-1:0]  idx_q;
   logic [IDX_W-1:0]  nxt_idx_c;
   logic              rd_phase_q;
   logic              last_c;
   logic              run_end_c;
   logic              nxt_rd_c;
   logic              mismatch_c;
   logic [DATA_W-1:0] wr_pat_c;
   logic [DATA_W-1:0] cmp_pat_c;

   ram_bist_pattern #(
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W),
      .SEED   (SEED)
   ) u_pat_wr (
      .idx       (nxt_idx_c),
      .pattern_c (wr_pat_c)
   );

   ram_bist_pattern #(
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W),
      .SEED   (SEED)
   ) u_pat_cmp (
      .idx       (idx_q),
      .pattern_c (cmp_pat_c)
   );

   // Sequencing decisions taken in GAP, plus the read comparator.
   always_comb begin
      start_mode_c = mode_t'(mode_i);
      last_c       = (idx_q == LAST_IDX);
      nxt_idx_c    = '0;
      if (state_q == ST_GAP && !last_c) begin
         nxt_idx_c = idx_q + IDX_W'(1);
      end
      run_end_c  = (mode_q == MODE_PROBE) ||
                   (last_c && (rd_phase_q || mode_q == MODE_LOAD));
      nxt_rd_c   = rd_phase_q | last_c;
      mismatch_c = rd_phase_q && (mode_q != MODE_PROBE) && (bus_data_i != cmp_pat_c);
   end

`ifdef RAM_BIST_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

   logic [TO_W-1:0] wd_q;
   logic            wd_expire_c;

   assign wd_expire_c = (state_q == ST_REQ) && !bus_ack_i &&
                        (wd_q == TO_W'(TIMEOUT_CYC - 1));

   // Counts consecutive REQ cycles without ack.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_q <= '0;
      end else if (state_q != ST_REQ || bus_ack_i || wd_expire_c) begin
         wd_q <= '0;
      end else begin
         wd_q <= wd_q + TO_W'(1);
      end
   end
`else
   assign timeout_o = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= ST_IDLE;
         mode_q           <= MODE_PROBE;
         idx_q            <= '0;
         rd_phase_q       <= 1'b0;
         bus_addr_o       <= '0;
         bus_data_o       <= '0;
         bus_ce_o         <= 1'b0;
         bus_we_o         <= 1'b0;
         busy_o           <= 1'b0;
         done_o           <= 1'b0;
         pass_o           <= 1'b0;
         err_count_o      <= '0;
         first_err_addr_o <= '0;
         rd_data_o        <= '0;
`ifdef RAM_BIST_TIMEOUT_EN
         timeout_o        <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start_i) begin
                  state_q          <= ST_REQ;
                  mode_q           <= start_mode_c;
                  idx_q            <= '0;
                  rd_phase_q       <= (start_mode_c == MODE_PROBE) ||
                                      (start_mode_c == MODE_VERIFY);
                  bus_addr_o       <= 32'((start_mode_c == MODE_PROBE) ? probe_addr_i : BASE_A);
                  bus_data_o       <= wr_pat_c;
                  bus_we_o         <= (start_mode_c == MODE_LOAD) ||
                                      (start_mode_c == MODE_LOADVER);
                  bus_ce_o         <= 1'b1;
                  busy_o           <= 1'b1;
                  done_o           <= 1'b0;
                  pass_o           <= 1'b0;
                  err_count_o      <= '0;
                  first_err_addr_o <= '0;
`ifdef RAM_BIST_TIMEOUT_EN
                  timeout_o        <= 1'b0;
`endif
               end
            end

            ST_REQ: begin
               if (bus_ack_i) begin
                  state_q  <= ST_GAP;
                  bus_ce_o <= 1'b0;
                  if (rd_phase_q) begin
                     rd_data_o <= bus_data_i;
                  end
                  if (mismatch_c) begin
                     if (err_count_o != '1) begin
                        err_count_o <= err_count_o + ERR_W'(1);
                     end
                     if (err_count_o == '0) begin
                        first_err_addr_o <= bus_addr_o[ADDR_W-1:0];
                     end
                  end
               end
`ifdef RAM_BIST_TIMEOUT_EN
               else if (wd_expire_c) begin
                  state_q   <= ST_DONE;
                  bus_ce_o  <= 1'b0;
                  busy_o    <= 1'b0;
                  done_o    <= 1'b1;
                  pass_o    <= 1'b0;
                  timeout_o <= 1'b1;
               end
`endif
            end

            ST_GAP: begin
               if (run_end_c) begin
                  state_q <= ST_DONE;
                  busy_o  <= 1'b0;
                  done_o  <= 1'b1;
                  pass_o  <= (err_count_o == '0);
               end else begin
                  // Load+verify rewinds to index 0 for the read pass.
                  state_q    <= ST_REQ;
                  idx_q      <= nxt_idx_c;
                  rd_phase_q <= nxt_rd_c;
                  bus_addr_o <= 32'(BASE_A + ADDR_W'(nxt_idx_c));
                  bus_data_o <= wr_pat_c;
                  bus_we_o   <= !nxt_rd_c;
                  bus_ce_o   <= 1'b1;
               end
            end

            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_bist_loader.sv
// Directed bench for ram_bist_loader with a behavioural RAM that acks on the falling edge.
module tb_ram_bist_loader;
   import ram_bist_pkg::*;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 20;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned BASE   = 32'h100;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [1:0]        mode = 2'b00;
   logic [ADDR_W-1:0] probe_addr = '0;
   logic [31:0]       bus_addr;
   logic [DATA_W-1:0] bus_wdata;
   logic [DATA_W-1:0] bus_rdata = '0;
   logic              bus_ce;
   logic              bus_we;
   logic              bus_ack = 1'b0;
   logic              busy;
   logic              done;
   logic              pass;
   logic              timeout;
   logic [15:0]       err_count;
   logic [ADDR_W-1:0] first_err_addr;
   logic [DATA_W-1:0] rd_data;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [0:1023];
   int ack_delay = 0;
   bit ack_en    = 1'b1;
   int wait_cnt  = 0;
   int wr_count  = 0;

   ram_bist_loader #(
      .DATA_W      (DATA_W),
      .ADDR_W      (ADDR_W),
      .LOAD_DEPTH  (DEPTH),
      .BASE_ADDR   (BASE),
      .SEED        (32'hA5A50000),
      .TIMEOUT_CYC (15)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .start_i          (start),
      .mode_i           (mode),
      .probe_addr_i     (probe_addr),
      .bus_addr_o       (bus_addr),
      .bus_data_o       (bus_wdata),
      .bus_data_i       (bus_rdata),
      .bus_ce_o         (bus_ce),
      .bus_we_o         (bus_we),
      .bus_ack_i        (bus_ack),
      .busy_o           (busy),
      .done_o           (done),
      .pass_o           (pass),
      .timeout_o        (timeout),
      .err_count_o      (err_count),
      .first_err_addr_o (first_err_addr),
      .rd_data_o        (rd_data)
   );

   always #5 clk = ~clk;

   // RAM model: one-cycle ack pulse after ack_delay waiting cycles.
   always @(negedge clk) begin
      if (bus_ack) begin
         bus_ack  = 1'b0;
         wait_cnt = 0;
      end else if (!bus_ce) begin
         wait_cnt = 0;
      end else if (ack_en) begin
         if (wait_cnt == ack_delay) begin
            bus_ack = 1'b1;
            if (bus_we) begin
               mem[bus_addr[9:0]] = bus_wdata;
               wr_count++;
            end else begin
               bus_rdata = mem[bus_addr[9:0]];
            end
         end else begin
            wait_cnt++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run(input logic [1:0] m, input logic [ADDR_W-1:0] pa);
      start      = 1'b1;
      mode       = m;
      probe_addr = pa;
      tick();
      start      = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int cyc);
      cyc = 0;
      while (!done && cyc < budget) begin
         tick();
         cyc++;
      end
   endtask

   task automatic test_reset();
      tick();
      tick();
      checks++;
      if (bus_ce !== 1'b0 || bus_we !== 1'b0 || bus_addr !== 32'h0)
         begin errors++; $display("FAIL reset_bus: ce=%b we=%b addr=%h required 0", bus_ce, bus_we, bus_addr); end
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || timeout !== 1'b0)
         begin errors++; $display("FAIL reset_flags: busy=%b done=%b pass=%b to=%b required 0", busy, done, pass, timeout); end
      checks++;
      if (err_count !== 16'h0 || first_err_addr !== 20'h0 || rd_data !== 32'h0)
         begin errors++; $display("FAIL reset_status: err=%h first=%h rd=%h required 0", err_count, first_err_addr, rd_data); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_load();
      int cyc;
      for (int i = 0; i < 4; i++) mem[256 + i] = 32'hDEADBEEF;
      ack_delay = 0;
      start_run(2'b01, '0);
      checks++;
      if (bus_ce !== 1'b1 || busy !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 32'h100)
         begin errors++; $display("FAIL load_first_req: ce=%b busy=%b we=%b addr=%h required 1 1 1 100", bus_ce, busy, bus_we, bus_addr); end
      wait_done(100, cyc);
      checks++;
      if (cyc != 8 || done !== 1'b1)
         begin errors++; $display("FAIL load_latency: cycles=%0d done=%b required 8 1", cyc, done); end
      checks++;
      if (mem[256] !== 32'hA5A50000) begin errors++; $display("FAIL load_w0: got %h required A5A50000", mem[256]); end
      checks++;
      if (mem[257] !== 32'hA5A50001) begin errors++; $display("FAIL load_w1: got %h required A5A50001", mem[257]); end
      checks++;
      if (mem[258] !== 32'hA5A50002) begin errors++; $display("FAIL load_w2: got %h required A5A50002", mem[258]); end
      checks++;
      if (mem[259] !== 32'hA5A50003) begin errors++; $display("FAIL load_w3: got %h required A5A50003", mem[259]); end
      checks++;
      if (pass !== 1'b1 || busy !== 1'b0 || err_count !== 16'h0)
         begin errors++; $display("FAIL load_pass: pass=%b busy=%b err=%h required 1 0 0", pass, busy, err_count); end
   endtask

   task automatic test_load_verify();
      int cyc = 0;
      int falls = 0;
      int low = 0;
      int bad = 0;
      logic prev_ce = 1'b1;
      ack_delay = 3;
      start_run(2'b10, '0);
      while (!done && cyc < 200) begin
         tick();
         cyc++;
         if (!bus_ce) begin
            if (prev_ce) begin falls++; low = 1; end
            else low++;
         end else if (!prev_ce) begin
            if (low != 1) bad++;
         end
         prev_ce = bus_ce;
      end
      checks++;
      if (cyc != 40 || done !== 1'b1)
         begin errors++; $display("FAIL lv_latency: cycles=%0d done=%b required 40 1", cyc, done); end
      checks++;
      if (falls != 8 || bad != 0)
         begin errors++; $display("FAIL lv_gaps: transactions=%0d bad_gaps=%0d required 8 0", falls, bad); end
      checks++;
      if (err_count !== 16'h0 || pass !== 1'b1)
         begin errors++; $display("FAIL lv_pass: err=%h pass=%b required 0 1", err_count, pass); end
      checks++;
      if (rd_data !== 32'hA5A50003)
         begin errors++; $display("FAIL lv_rd_data: got %h required A5A50003", rd_data); end
   endtask

   task automatic test_verify_error();
      int cyc;
      mem[258] = 32'h0;
      ack_delay = 0;
      start_run(2'b11, '0);
      checks++;
      if (bus_we !== 1'b0 || bus_addr !== 32'h100)
         begin errors++; $display("FAIL ver_first_req: we=%b addr=%h required 0 100", bus_we, bus_addr); end
      wait_done(100, cyc);
      checks++;
      if (cyc != 8 || done !== 1'b1)
         begin errors++; $display("FAIL ver_latency: cycles=%0d done=%b required 8 1", cyc, done); end
      checks++;
      if (err_count !== 16'h1) begin errors++; $display("FAIL ver_err_count: got %h required 1", err_count); end
      checks++;
      if (first_err_addr !== 20'h102) begin errors++; $display("FAIL ver_first_err: got %h required 102", first_err_addr); end
      checks++;
      if (pass !== 1'b0) begin errors++; $display("FAIL ver_pass: got %b required 0", pass); end
   endtask

   task automatic test_probe_busy_start();
      int wr0 = wr_count;
      ack_delay = 0;
      start_run(2'b00, 20'h103);
      checks++;
      if (bus_addr !== 32'h103 || bus_we !== 1'b0 || busy !== 1'b1)
         begin errors++; $display("FAIL probe_req: addr=%h we=%b busy=%b required 103 0 1", bus_addr, bus_we, busy); end
      // Hold start high through REQ and GAP; it must not restart the run.
      start = 1'b1;
      mode  = 2'b01;
      tick();
      tick();
      start = 1'b0;
      checks++;
      if (done !== 1'b1 || rd_data !== 32'hA5A50003)
         begin errors++; $display("FAIL probe_data: done=%b rd=%h required 1 A5A50003", done, rd_data); end
      checks++;
      if (pass !== 1'b1 || err_count !== 16'h0 || first_err_addr !== 20'h0)
         begin errors++; $display("FAIL probe_pass: pass=%b err=%h first=%h required 1 0 0", pass, err_count, first_err_addr); end
      tick();
      tick();
      tick();
      checks++;
      if (wr_count != wr0 || busy !== 1'b0 || bus_ce !== 1'b0 || done !== 1'b1)
         begin errors++; $display("FAIL busy_start_ignored: writes=%0d busy=%b ce=%b done=%b required %0d 0 0 1", wr_count, busy, bus_ce, done, wr0); end
   endtask

   task automatic test_reset_midrun();
      int cyc = 0;
      int wr0 = wr_count;
      for (int i = 0; i < 4; i++) mem[256 + i] = 32'h0;
      ack_delay = 2;
      start_run(2'b01, '0);
      while (!((wr_count - wr0) == 2 && bus_ce) && cyc < 100) begin
         tick();
         cyc++;
      end
      checks++;
      if (!((wr_count - wr0) == 2 && bus_ce === 1'b1 && bus_addr === 32'h102))
         begin errors++; $display("FAIL rst_third_write: writes=%0d ce=%b addr=%h required 2 1 102", wr_count - wr0, bus_ce, bus_addr); end
      rst = 1'b1;
      #1;
      checks++;
      if (bus_ce !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || bus_addr !== 32'h0 || bus_wdata !== 32'h0 || bus_we !== 1'b0)
         begin errors++; $display("FAIL rst_async_clear: ce=%b busy=%b done=%b addr=%h data=%h we=%b required all 0", bus_ce, busy, done, bus_addr, bus_wdata, bus_we); end
      checks++;
      if (pass !== 1'b0 || rd_data !== 32'h0 || err_count !== 16'h0)
         begin errors++; $display("FAIL rst_async_status: pass=%b rd=%h err=%h required 0", pass, rd_data, err_count); end
      tick();
      tick();
      rst = 1'b0;
      tick();
      ack_delay = 0;
      start_run(2'b01, '0);
      wait_done(100, cyc);
      checks++;
      if (cyc != 8 || pass !== 1'b1)
         begin errors++; $display("FAIL rst_rerun: cycles=%0d pass=%b required 8 1", cyc, pass); end
      checks++;
      if (mem[258] !== 32'hA5A50002 || mem[259] !== 32'hA5A50003)
         begin errors++; $display("FAIL rst_rerun_data: w2=%h w3=%h required A5A50002 A5A50003", mem[258], mem[259]); end
   endtask

   task automatic test_timeout();
      int cyc = 0;
`ifdef RAM_BIST_TIMEOUT_EN
      int ce_cyc = 1;
      ack_en = 1'b0;
      start_run(2'b11, '0);
      while (!done && cyc < 100) begin
         tick();
         cyc++;
         if (bus_ce) ce_cyc++;
      end
      checks++;
      if (ce_cyc != 15 || timeout !== 1'b1)
         begin errors++; $display("FAIL timeout_fire: ce_cycles=%0d to=%b required 15 1", ce_cyc, timeout); end
      checks++;
      if (done !== 1'b1 || pass !== 1'b0 || bus_ce !== 1'b0 || busy !== 1'b0)
         begin errors++; $display("FAIL timeout_state: done=%b pass=%b ce=%b busy=%b required 1 0 0 0", done, pass, bus_ce, busy); end
      ack_en = 1'b1;
      start_run(2'b01, '0);
      checks++;
      if (timeout !== 1'b0 || done !== 1'b0)
         begin errors++; $display("FAIL timeout_clear: to=%b done=%b required 0 0", timeout, done); end
      wait_done(100, cyc);
      checks++;
      if (pass !== 1'b1) begin errors++; $display("FAIL timeout_rerun: pass=%b required 1", pass); end
`else
      ack_en = 1'b0;
      start_run(2'b11, '0);
      for (int i = 0; i < 40; i++) begin
         tick();
         cyc++;
      end
      checks++;
      if (timeout !== 1'b0 || bus_ce !== 1'b1 || busy !== 1'b1 || done !== 1'b0)
         begin errors++; $display("FAIL no_watchdog: to=%b ce=%b busy=%b done=%b after %0d cycles required 0 1 1 0", timeout, bus_ce, busy, done, cyc); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ack_en = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b0 || bus_ce !== 1'b0)
         begin errors++; $display("FAIL no_watchdog_recover: busy=%b ce=%b required 0 0", busy, bus_ce); end
`endif
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      test_reset();
      test_load();
      test_load_verify();
      test_verify_error();
      test_probe_busy_start();
      test_reset_midrun();
      test_timeout();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not finish within 200000 time units");
      $fatal(1);
   end

endmodule
